// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory under a
// credit limit, and hands {pc, instr} pairs to decode in order through a small FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int          CW       = $clog2(FIFO_DEPTH + 1);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] LP_NOP   = 32'h0000_0013;

  typedef enum logic {
    S_RESET_WAIT = 1'b0,
    S_FETCH      = 1'b1
  } state_e;

  // Handshakes: memory request issues on imem_req_o && imem_gnt_i; a response is one
  // cycle of imem_rvalid_i; decode pops the head on valid_o && ready_i.
  state_e r_state;
  state_e w_state_next;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_tag_wptr;
  logic [AW-1:0] r_tag_rptr;

  logic [31:0] r_instr_mem [FIFO_DEPTH];
  logic [31:0] r_pc_mem    [FIFO_DEPTH];
  logic [31:0] r_tag_mem   [FIFO_DEPTH];

  logic          w_issue;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_credit_used;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_drop_next;
  logic [CW-1:0] w_count_next;
  logic [1:0]    w_unused_pc_lsb;

  assign w_unused_pc_lsb = redirect_pc_i[1:0];

  // Outstanding requests include stale ones still to be dropped, so a response always
  // finds room in the FIFO when it arrives.
  assign w_credit_used = {1'b0, r_out} + {1'b0, r_count};

  always_comb begin
    w_state_next = r_state;
    imem_req_o   = 1'b0;
    case (r_state)
      S_RESET_WAIT: w_state_next = S_FETCH;
      S_FETCH: begin
        w_state_next = S_FETCH;
        imem_req_o   = !redirect_i && (w_credit_used < LP_DEPTH);
      end
      default: w_state_next = S_RESET_WAIT;
    endcase
  end

  assign imem_addr_o = r_pc;

  assign w_issue = imem_req_o && imem_gnt_i;
  assign w_resp  = imem_rvalid_i && (r_out != '0);
  assign w_push  = w_resp && (r_drop == '0) && !redirect_i;
  assign w_pop   = (r_count != '0) && ready_i && !redirect_i;

  always_comb begin
    w_out_next   = r_out + CW'(w_issue) - CW'(w_resp);
    w_drop_next  = r_drop;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_drop_next  = w_out_next;
      w_count_next = '0;
    end else if (w_resp && (r_drop != '0)) begin
      w_drop_next = r_drop - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_RESET_WAIT;
      r_pc       <= RESET_VECTOR;
      r_out      <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      r_drop  <= w_drop_next;
      r_count <= w_count_next;
      if (redirect_i) begin
        r_pc <= {redirect_pc_i[31:2], 2'b00};
      end else if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      if (redirect_i) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_tag_wptr <= '0;
        r_tag_rptr <= '0;
      end else begin
        if (w_issue) r_tag_wptr <= r_tag_wptr + AW'(1);
        if (w_push)  r_tag_rptr <= r_tag_rptr + AW'(1);
        if (w_push)  r_wptr     <= r_wptr + AW'(1);
        if (w_pop)   r_rptr     <= r_rptr + AW'(1);
      end
    end
  end

  // Tag FIFO records the PC of each issued request; responses pair with it in issue order.
  always_ff @(posedge clk_i) begin
    if (w_issue) begin
      r_tag_mem[r_tag_wptr] <= r_pc;
    end
    if (w_push) begin
      r_instr_mem[r_wptr] <= imem_rdata_i;
      r_pc_mem[r_wptr]    <= r_tag_mem[r_tag_rptr];
    end
  end

  assign valid_o = (r_count != '0);
  assign instr_o = valid_o ? r_instr_mem[r_rptr] : LP_NOP;
  assign pc_o    = valid_o ? r_pc_mem[r_rptr] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reactive instruction memory, epoch-based reference model of the
// expected decode stream, and per-scenario tasks.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // expected decode stream {pc, instr}
  logic [63:0] exp_q[$];
  // memory model: in-flight requests
  logic [31:0] mem_addr_q[$];
  logic [31:0] mem_pc_q[$];
  int          mem_ep_q[$];
  int          mem_t_q[$];
  logic [31:0] iss_q[$];

  logic [31:0] exp_pc = 32'h0;
  int epoch     = 0;
  int gnt_pct   = 100;
  int ready_pct = 100;
  int lat_fix   = 0;
  int lat_rand  = 0;

  logic        s_req, s_valid, last_issue;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit exp_req, exp_valid, rv;
    logic [63:0] head;
    @(negedge clk_i);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    ready_i       = ($urandom_range(99) < ready_pct);
    rv = (mem_addr_q.size() != 0) && (mem_t_q[0] <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(mem_addr_q[0]) : $urandom();
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = valid_o; s_pc = pc_o; s_instr = instr_o;
    exp_req   = !redir && ((mem_addr_q.size() + exp_q.size()) < DEPTH);
    exp_valid = (exp_q.size() != 0);
    n_tests++;
    if (imem_req_o !== exp_req) begin
      n_fail++;
      $display("FAIL req cyc=%0d got=%b exp=%b", cyc, imem_req_o, exp_req);
    end
    if (exp_req) begin
      n_tests++;
      if (imem_addr_o !== exp_pc) begin
        n_fail++;
        $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, exp_pc);
      end
    end
    n_tests++;
    if (valid_o !== exp_valid) begin
      n_fail++;
      $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid_o, exp_valid);
    end
    head = exp_valid ? exp_q[0] : {32'h0, NOP};
    n_tests++;
    if ({pc_o, instr_o} !== head) begin
      n_fail++;
      $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
               cyc, pc_o, instr_o, head[63:32], head[31:0]);
    end
    if (exp_valid && ready_i && !redir) void'(exp_q.pop_front());
    if (redir) exp_q.delete();
    if (rv) begin
      if (!redir && (mem_ep_q[0] == epoch))
        exp_q.push_back({mem_pc_q[0], mem_word(mem_pc_q[0])});
      void'(mem_addr_q.pop_front());
      void'(mem_pc_q.pop_front());
      void'(mem_ep_q.pop_front());
      void'(mem_t_q.pop_front());
    end
    last_issue = imem_req_o && imem_gnt_i;
    if (last_issue) begin
      mem_addr_q.push_back(imem_addr_o);
      mem_pc_q.push_back(exp_pc);
      mem_ep_q.push_back(epoch);
      mem_t_q.push_back(cyc + 1 + lat_fix + int'($urandom_range(lat_rand)));
      iss_q.push_back(imem_addr_o);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      epoch++;
      exp_pc = rpc & ~32'h3;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    redirect_i = 1'b0; imem_rvalid_i = 1'b0; ready_i = 1'b0; imem_gnt_i = 1'b1;
    exp_q.delete(); mem_addr_q.delete(); mem_pc_q.delete(); mem_ep_q.delete(); mem_t_q.delete();
    iss_q.delete();
    exp_pc = 32'h0;
    epoch++;
    #1;
    n_tests++;
    if ({imem_req_o, valid_o, instr_o, pc_o} !== {1'b0, 1'b0, NOP, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_out got req=%b valid=%b instr=%h pc=%h", imem_req_o, valid_o, instr_o, pc_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_tests++;
    if (imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wait_req got=%b exp=0", imem_req_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (imem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr got=%h exp=00000000", imem_addr_o);
    end
  endtask

  task automatic test_basic();
    int first_valid, pops;
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_fix = 0; lat_rand = 0;
    first_valid = -1; pops = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 32'h0);
      if (s_valid && first_valid < 0) begin
        first_valid = i;
        n_tests++;
        if (s_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL basic_first_pc got=%h exp=00000000", s_pc);
        end
      end
      if (s_valid) pops++;
    end
    n_tests++;
    if (first_valid != 3) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d exp=3", first_valid);
    end
    n_tests++;
    if (pops != 7) begin
      n_fail++;
      $display("FAIL basic_pops got=%0d exp=7", pops);
    end
  endtask

  task automatic test_stall();
    int grants;
    logic [31:0] hold_pc, hold_instr;
    bit held;
    do_reset();
    gnt_pct = 100; ready_pct = 0; lat_fix = 0; lat_rand = 0;
    grants = 0; held = 1'b0; hold_pc = 32'h0; hold_instr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0);
      if (last_issue) grants++;
      if (s_valid && held) begin
        n_tests++;
        if ({s_pc, s_instr} !== {hold_pc, hold_instr}) begin
          n_fail++;
          $display("FAIL stall_stable got=%h/%h exp=%h/%h", s_pc, s_instr, hold_pc, hold_instr);
        end
      end
      if (s_valid && !held) begin
        held = 1'b1; hold_pc = s_pc; hold_instr = s_instr;
      end
    end
    n_tests++;
    if (grants != 2) begin
      n_fail++;
      $display("FAIL stall_grants got=%0d exp=2", grants);
    end
    n_tests++;
    if (s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req_off got=%b exp=0", s_req);
    end
    ready_pct = 100;
    repeat (10) cycle(1'b0, 32'h0);
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_fix = 4; lat_rand = 0;
    repeat (3) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h0000_0103);
    lat_fix = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 32'h0);
      if (s_req) begin
        seen = 1'b1;
        n_tests++;
        if (s_addr !== 32'h0000_0100) begin
          n_fail++;
          $display("FAIL redir_addr got=%h exp=00000100", s_addr);
        end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL redir_addr got=none exp=00000100"); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 32'h0);
      if (s_valid) begin
        seen = 1'b1;
        n_tests++;
        if ({s_pc, s_instr} !== {32'h0000_0100, mem_word(32'h0000_0100)}) begin
          n_fail++;
          $display("FAIL redir_first got=%h/%h exp=00000100/%h", s_pc, s_instr, mem_word(32'h100));
        end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL redir_first got=timeout exp=valid"); end
  endtask

  task automatic test_redirect_rvalid();
    bit seen;
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_fix = 1; lat_rand = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_addr_q.size() >= 2 && mem_t_q[0] <= cyc) break;
      cycle(1'b0, 32'h0);
    end
    cycle(1'b1, 32'h0000_0200);
    gnt_pct = 0;
    for (int i = 0; i < 10 && mem_addr_q.size() != 0; i++) cycle(1'b0, 32'h0);
    cycle(1'b0, 32'h0);
    n_tests++;
    if (s_req !== 1'b1 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_rv_idle got req=%b valid=%b exp req=1 valid=0", s_req, s_valid);
    end
    gnt_pct = 100; lat_fix = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 32'h0);
      if (s_valid) begin
        seen = 1'b1;
        n_tests++;
        if (s_pc !== 32'h0000_0200) begin
          n_fail++;
          $display("FAIL redir_rv_first got=%h exp=00000200", s_pc);
        end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL redir_rv_first got=timeout exp=valid"); end
  endtask

  task automatic test_wrap_random();
    logic [31:0] want [4];
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_fix = 0; lat_rand = 0;
    cycle(1'b1, 32'hFFFF_FFF8);
    iss_q.delete();
    for (int i = 0; i < 30 && iss_q.size() < 4; i++) cycle(1'b0, 32'h0);
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0; want[3] = 32'h4;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= iss_q.size()) begin
        n_fail++;
        $display("FAIL wrap_addr%0d got=none exp=%h", i, want[i]);
      end else if (iss_q[i] !== want[i]) begin
        n_fail++;
        $display("FAIL wrap_addr%0d got=%h exp=%h", i, iss_q[i], want[i]);
      end
    end
    gnt_pct = 60; ready_pct = 50; lat_rand = 3;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 3) cycle(1'b1, $urandom());
      else cycle(1'b0, 32'h0);
    end
    gnt_pct = 100; ready_pct = 100; lat_rand = 0;
    repeat (30) cycle(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    gnt_pct = 100; ready_pct = 50; lat_fix = 0; lat_rand = 2;
    repeat (15) cycle(1'b0, 32'h0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({imem_req_o, valid_o, instr_o, pc_o} !== {1'b0, 1'b0, NOP, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset got req=%b valid=%b instr=%h pc=%h", imem_req_o, valid_o, instr_o, pc_o);
    end
    do_reset();
    @(negedge clk_i);
    imem_gnt_i = 1'b0; ready_i = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0;
    #1;
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rvalid got valid=%b exp=0", valid_o);
    end
    ready_pct = 100; lat_rand = 0;
    iss_q.delete();
    repeat (10) cycle(1'b0, 32'h0);
    n_tests++;
    if (iss_q.size() == 0 || iss_q[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL restart_addr got=%h exp=00000000", (iss_q.size() == 0) ? 32'hFFFF_FFFF : iss_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_wrap_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
